mul_result_combine: RTL and testbench

MUL_RESULT_COMBINE -- requirements
Module: mul_result_combine

---
 rtl/mul_result_combine_if.sv | 27 ++
 rtl/mul_result_combine.sv | 85 ++++++++
 tb/tb_mul_result_combine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_result_combine_if.sv
// Handshake bundle between a partial-product producer and the mul_result_combine pipeline.
// The master modport drives operands, tag, flush and out_ready. The slave modport drives in_ready and the result.
interface mul_result_combine_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_p1;
  logic [31:0]      in_p2;
  logic [31:0]      in_p3;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_p1, in_p2, in_p3, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_p1, in_p2, in_p3, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_result_combine.sv
// Folds three 16x16 partial products into the low 32 bits of a 32x32 product. The result appears 2 cycles after accept, at one op per cycle.
// Both stages stall together under out_ready backpressure, with at most 2 ops in flight. Flush and reset drop everything in flight.
module mul_result_combine #(
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  mul_result_combine_if.slave    bus,
  output logic [15:0]            ops_done
);

  typedef struct packed {
    logic [31:0]      p1;
    logic [15:0]      mid;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic             s1_valid;
  s1_t              s1;
  logic             s2_valid;
  logic [31:0]      s2_result;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic             s1_adv;
  logic             out_fire;
  logic [15:0]      mid_sum;
  logic [31:0]      final_sum;
  logic             unused_hi;

  // Only the low halves of the cross products land inside the low 32 result bits.
  assign mid_sum   = bus.in_p2[15:0] + bus.in_p3[15:0];
  assign final_sum = s1.p1 + {s1.mid, 16'h0000};
  assign unused_hi = ^{bus.in_p2[31:16], bus.in_p3[31:16]};

  assign s2_load   = !s2_valid || bus.out_ready;
  assign s1_adv    = !s1_valid || s2_load;
  assign out_fire  = s2_valid && bus.out_ready && !bus.flush;

  assign bus.in_ready   = !reset && !bus.flush && s1_adv;
  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
  assign bus.out_tag    = s2_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1.p1  <= bus.in_p1;
        s1.mid <= mid_sum;
        s1.tag <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (bus.flush) begin
      s2_valid  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= final_sum;
        s2_tag    <= s1.tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_done <= '0;
    end else if (out_fire) begin
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul_result_combine.sv
module tb_mul_result_combine;
  localparam int TAG_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ops_done;

  mul_result_combine_if #(.TAG_W(TAG_W)) bus ();

  mul_result_combine #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ops = 0;

  logic [31:0]      vp1  [8];
  logic [31:0]      vp2  [8];
  logic [31:0]      vp3  [8];
  logic [TAG_W-1:0] vtag [8];
  logic [31:0]      vexp [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [TAG_W-1:0] tg, input logic [31:0] ex);
    vp1[i] = p1; vp2[i] = p2; vp3[i] = p3; vtag[i] = tg; vexp[i] = ex;
  endtask

  // Streams n vectors, holding out_ready low for cycles stall_lo..stall_hi; checks order, hold and timing.
  task automatic run_stream(input string name, input int n, input int stall_lo,
                            input int stall_hi, input int exp_last);
    int idx = 0, oidx = 0, c = 0, first = -1, last = -1;
    logic acc;
    while (oidx < n && c < 200) begin
      bus.out_ready = !(c >= stall_lo && c <= stall_hi);
      bus.in_valid  = (idx < n);
      bus.in_p1     = (idx < n) ? vp1[idx]  : '0;
      bus.in_p2     = (idx < n) ? vp2[idx]  : '0;
      bus.in_p3     = (idx < n) ? vp3[idx]  : '0;
      bus.in_tag    = (idx < n) ? vtag[idx] : '0;
      #1;
      if (bus.out_valid) begin
        chk({name, "_result"}, bus.out_result, vexp[oidx]);
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(vtag[oidx]));
      end
      if (stall_lo >= 0 && c == stall_lo) begin
        chk({name, "_in_ready_full"}, 32'(bus.in_ready), 0);
        chk({name, "_in_flight"}, idx - oidx, 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first < 0) first = c;
        last = c;
        oidx++;
        exp_ops++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idx++;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk({name, "_count"}, oidx, n);
    chk({name, "_first_cycle"}, first, 2);
    chk({name, "_last_cycle"}, last, exp_last);
    chk({name, "_ops_done"}, 32'(ops_done), 32'(exp_ops[15:0]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen, bub, bad, hs;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_p1 = '0; bus.in_p2 = '0; bus.in_p3 = '0;
    bus.in_tag = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Basic op: mid = 0xC + 0xA = 0x16.
    bus.in_valid = 1'b1; bus.in_p1 = 32'h0000000F; bus.in_p2 = 32'h0000000C;
    bus.in_p3 = 32'h0000000A; bus.in_tag = 5'd3; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("basic_lat1_valid", 32'(bus.out_valid), 0);
    step();
    chk("basic_valid", 32'(bus.out_valid), 1);
    chk("basic_result", bus.out_result, 32'h0016000F);
    chk("basic_tag", 32'(bus.out_tag), 3);
    chk("basic_ops_pre", 32'(ops_done), 0);
    step();
    exp_ops = 1;
    chk("basic_drained", 32'(bus.out_valid), 0);
    chk("basic_ops_done", 32'(ops_done), 1);

    // Modular wrap of both adders.
    set_vec(0, 32'hFFFF0000, 32'h00000001, 32'h00000000, 5'd7, 32'h00000000);
    set_vec(1, 32'hFFFFFFFF, 32'h0001FFFF, 32'hABCD0001, 5'd8, 32'hFFFFFFFF);
    run_stream("wrap", 2, -1, -2, 3);

    // Backpressure: five ops, out_ready low on cycles 3..6.
    set_vec(0, 32'h00000001, 32'h00000001, 32'h00000001, 5'd1, 32'h00020001);
    set_vec(1, 32'h00001000, 32'h00000010, 32'h00000020, 5'd2, 32'h00301000);
    set_vec(2, 32'h12345678, 32'h00000100, 32'h00000200, 5'd3, 32'h15345678);
    set_vec(3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd4, 32'h0000FFFF);
    set_vec(4, 32'h00000000, 32'hDEAD8000, 32'hBEEF8001, 5'd5, 32'h00010000);
    run_stream("bp", 5, 3, 6, 10);

    // Flush with two ops in flight and a third presented.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_p2 = '0; bus.in_p3 = '0;
    bus.in_p1 = 32'h11; bus.in_tag = 5'd10;
    step();
    bus.in_p1 = 32'h22; bus.in_tag = 5'd11;
    step();
    bus.in_p1 = 32'h33; bus.in_tag = 5'd12; bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    chk("flush_pre_valid", 32'(bus.out_valid), 1);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_ops_done", 32'(ops_done), 32'(exp_ops[15:0]));
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("flush_no_output", seen, 0);
    chk("flush_ops_after", 32'(ops_done), 32'(exp_ops[15:0]));

    // Reset while stage 2 holds a stalled result.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_p1 = 32'h5; bus.in_p2 = 32'h1; bus.in_p3 = 32'h0; bus.in_tag = 5'd9;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("rmid_s2_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    exp_ops = 0;
    chk("rmid_out_valid", 32'(bus.out_valid), 0);
    chk("rmid_ops_done", 32'(ops_done), 0);
    chk("rmid_out_result", bus.out_result, 0);
    chk("rmid_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rmid_release_ready", 32'(bus.in_ready), 1);
    set_vec(0, 32'h00000005, 32'h00000001, 32'h00000000, 5'd9, 32'h00010005);
    run_stream("rmid_next", 1, -1, -2, 2);

    // Counter wrap: 65537 full-rate handshakes from a fresh reset.
    reset = 1'b1;
    #1 reset = 1'b0;
    exp_ops = 0;
    bub = 0; bad = 0; hs = 0;
    bus.out_ready = 1'b1; bus.in_p2 = '0; bus.in_p3 = '0; bus.in_tag = '0;
    for (int c = 0; c < 65540; c++) begin
      bus.in_valid = (c < 65537);
      bus.in_p1    = 32'(c);
      #1;
      if (c >= 2 && c < 65539) begin
        if (!bus.out_valid) bub++;
        else if (bus.out_result !== 32'(c - 2)) bad++;
      end
      if (bus.in_valid && !bus.in_ready) bub++;
      if (bus.out_valid && bus.out_ready) hs++;
      step();
      if (c == 65537) chk("cnt_wrap_zero", 32'(ops_done), 0);
    end
    bus.in_valid = 1'b0;
    chk("cnt_handshakes", hs, 65537);
    chk("cnt_ops_done", 32'(ops_done), 32'h0001);
    chk("cnt_bubbles", bub, 0);
    chk("cnt_data", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
